// File: rtl/gpu_pkg.sv
// Types, widths and coordinate helpers shared by the rasteriser texture blocks.
package gpu_pkg;

    localparam int unsigned GPU_COLOR_WIDTH = 12;
    localparam int unsigned GPU_UV_WIDTH    = 8;

    typedef logic [GPU_COLOR_WIDTH-1:0] color_t;

    typedef enum logic {
        StIdle,
        StLoad
    } up_state_e;

    // Maps a texel coordinate into [0, dim-1]: saturate when clamping, else modulo (dim is 2^n).
    function automatic logic [31:0] clamp_wrap_coord(input logic [31:0] coord,
                                                     input int unsigned dim,
                                                     input bit clamp);
        if (clamp) begin
            return (coord >= dim) ? dim - 1 : coord;
        end
        return coord & (dim - 1);
    endfunction

endpackage

// File: rtl/texture_bank.sv
// Simple dual-port texel RAM: one write port, one registered read-first read port, no reset.
module texture_bank #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Read and write share one block so a colliding read sees the pre-write contents.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/texture_atlas_ram.sv
// Multi-texture store: auto-addressing upload FSM plus a 2-cycle pipelined wrap/clamp texel fetch.
module texture_atlas_ram
    import gpu_pkg::*;
#(
    parameter int unsigned COLOR_WIDTH = GPU_COLOR_WIDTH,
    parameter int unsigned TEX_DIM     = 64,
    parameter int unsigned NUM_TEX     = 16,
    parameter int unsigned UV_WIDTH    = GPU_UV_WIDTH,
    parameter int unsigned CLAMP       = 0,
    localparam int unsigned DIM_W      = $clog2(TEX_DIM),
    localparam int unsigned ID_W       = (NUM_TEX > 1) ? $clog2(NUM_TEX) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_up_start,
    input  logic [ID_W:0]          i_up_tex_id,
    input  logic                   i_up_valid,
    input  logic [COLOR_WIDTH-1:0] i_up_color,
    output logic                   o_up_ready,
    output logic                   o_up_busy,
    output logic                   o_up_done,
    output logic                   o_up_err,
    input  logic                   i_rd_valid,
    input  logic [ID_W:0]          i_rd_tex_id,
    input  logic [UV_WIDTH-1:0]    i_rd_u,
    input  logic [UV_WIDTH-1:0]    i_rd_v,
    output logic                   o_rd_out_valid,
    output logic [COLOR_WIDTH-1:0] o_rd_color
);

    localparam int unsigned CNT_W  = 2 * DIM_W;
    localparam int unsigned ADDR_W = ID_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(TEX_DIM * TEX_DIM - 1);
    localparam logic [ID_W:0]    NUM_TEX_ID = (ID_W + 1)'(NUM_TEX);

    up_state_e         r_state;
    up_state_e         w_state_d;
    logic [ID_W-1:0]   r_id;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic              r_err;
    logic              w_beat;
    logic              w_up_id_ok;
    logic              w_accept;

    logic [DIM_W-1:0]  w_u;
    logic [DIM_W-1:0]  w_v;
    logic              w_rd_id_ok;
    logic              r_s1_valid;
    logic              r_s1_ok;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_s2_valid;
    logic              r_s2_ok;
    logic [COLOR_WIDTH-1:0] w_bank_q;

    assign w_up_id_ok = (i_up_tex_id < NUM_TEX_ID);
    assign w_accept   = (r_state == StIdle) && i_up_start && w_up_id_ok;
    assign o_up_ready = (r_state == StLoad);
    assign o_up_busy  = (r_state == StLoad);
    assign w_beat     = i_up_valid && o_up_ready;
    assign o_up_done  = r_done;
    assign o_up_err   = r_err;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StLoad;
                end
            end
            StLoad: begin
                if (w_beat && (r_cnt == LAST_BEAT)) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_id    <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_done  <= w_beat && (r_cnt == LAST_BEAT);
            r_err   <= (r_state == StIdle) && i_up_start && !w_up_id_ok;
            if (w_accept) begin
                r_id  <= i_up_tex_id[ID_W-1:0];
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_u        = DIM_W'(clamp_wrap_coord(32'(i_rd_u), TEX_DIM, CLAMP != 0));
    assign w_v        = DIM_W'(clamp_wrap_coord(32'(i_rd_v), TEX_DIM, CLAMP != 0));
    assign w_rd_id_ok = (i_rd_tex_id < NUM_TEX_ID);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ok    <= 1'b0;
            r_s1_addr  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_ok    <= 1'b0;
        end else begin
            r_s1_valid <= i_rd_valid;
            r_s1_ok    <= w_rd_id_ok;
            r_s1_addr  <= {i_rd_tex_id[ID_W-1:0], w_v, w_u};
            r_s2_valid <= r_s1_valid;
            // Only refreshed with the RAM output so the colour holds between results.
            if (r_s1_valid) begin
                r_s2_ok <= r_s1_ok;
            end
        end
    end

    assign o_rd_out_valid = r_s2_valid;
    assign o_rd_color     = r_s2_ok ? w_bank_q : '0;

    texture_bank #(
        .DATA_W (COLOR_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .i_clk   (i_clk),
        .i_we    (w_beat),
        .i_waddr ({r_id, r_cnt}),
        .i_wdata (i_up_color),
        .i_re    (r_s1_valid),
        .i_raddr (r_s1_addr),
        .o_rdata (w_bank_q)
    );

endmodule

// File: tb/tb_texture_atlas_ram.sv
// Bench: a wrap and a clamp instance share stimulus; reads are scored against an array model.
module tb_texture_atlas_ram;

    localparam int unsigned DIM    = 64;
    localparam int unsigned NT     = 16;
    localparam int unsigned TEXELS = DIM * DIM;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        up_start = 1'b0;
    logic [4:0]  up_tex_id = '0;
    logic        up_valid = 1'b0;
    logic [11:0] up_color = '0;
    logic        rd_valid = 1'b0;
    logic [4:0]  rd_tex_id = '0;
    logic [7:0]  rd_u = '0;
    logic [7:0]  rd_v = '0;

    logic        ready0, busy0, done0, err0, ov0;
    logic        ready1, busy1, done1, err1, ov1;
    logic [11:0] col0, col1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [11:0] m_mem [NT*TEXELS];
    bit          m_wr  [NT*TEXELS];

    typedef struct {
        int          due;
        logic [11:0] c0;
        logic [11:0] c1;
        bit          k0;
        bit          k1;
    } exp_t;
    exp_t q[$];

    typedef struct {
        int          id;
        int          u;
        int          v;
        logic [11:0] e0;
        logic [11:0] e1;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    texture_atlas_ram #(.CLAMP(0)) u_dut_wrap (
        .i_clk (clk), .i_rst (rst),
        .i_up_start (up_start), .i_up_tex_id (up_tex_id), .i_up_valid (up_valid),
        .i_up_color (up_color), .o_up_ready (ready0), .o_up_busy (busy0),
        .o_up_done (done0), .o_up_err (err0),
        .i_rd_valid (rd_valid), .i_rd_tex_id (rd_tex_id), .i_rd_u (rd_u), .i_rd_v (rd_v),
        .o_rd_out_valid (ov0), .o_rd_color (col0)
    );

    texture_atlas_ram #(.CLAMP(1)) u_dut_clamp (
        .i_clk (clk), .i_rst (rst),
        .i_up_start (up_start), .i_up_tex_id (up_tex_id), .i_up_valid (up_valid),
        .i_up_color (up_color), .o_up_ready (ready1), .o_up_busy (busy1),
        .o_up_done (done1), .o_up_err (err1),
        .i_rd_valid (rd_valid), .i_rd_tex_id (rd_tex_id), .i_rd_u (rd_u), .i_rd_v (rd_v),
        .o_rd_out_valid (ov1), .o_rd_color (col1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Texel lookup straight from the addressing rules; unknown when never uploaded.
    function automatic logic [11:0] ref_read(input int id, input int u, input int v,
                                             input bit clamp, output bit known);
        int uu;
        int vv;
        if (id >= int'(NT)) begin
            known = 1'b1;
            return '0;
        end
        if (clamp) begin
            uu = (u >= int'(DIM)) ? int'(DIM) - 1 : u;
            vv = (v >= int'(DIM)) ? int'(DIM) - 1 : v;
        end else begin
            uu = u % int'(DIM);
            vv = v % int'(DIM);
        end
        known = m_wr[id*TEXELS + vv*DIM + uu];
        return m_mem[id*TEXELS + vv*DIM + uu];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done0) done_cnt++;

    logic [11:0] h0 = '0;
    logic [11:0] h1 = '0;
    bit          hk0 = 1'b1;
    bit          hk1 = 1'b1;

    // Read scoreboard: result due two cycles after request; colour holds between results.
    always @(negedge clk) begin
        exp_t it;
        bit   ev;
        if (rst) begin
            q.delete();
            h0 = '0; h1 = '0; hk0 = 1'b1; hk1 = 1'b1;
        end else begin
            ev = 1'b0;
            if (q.size() != 0 && q[0].due == cyc) begin
                it = q.pop_front();
                ev = 1'b1;
                h0 = it.c0; hk0 = it.k0;
                h1 = it.c1; hk1 = it.k1;
            end
            chk("rd_out_valid wrap", 32'(ov0), 32'(ev));
            chk("rd_out_valid clamp", 32'(ov1), 32'(ev));
            if (hk0) chk("rd_color wrap", 32'(col0), 32'(h0));
            if (hk1) chk("rd_color clamp", 32'(col1), 32'(h1));
            if (rd_valid) begin
                it.due = cyc + 2;
                it.c0  = ref_read(int'(rd_tex_id), int'(rd_u), int'(rd_v), 1'b0, it.k0);
                it.c1  = ref_read(int'(rd_tex_id), int'(rd_u), int'(rd_v), 1'b1, it.k1);
                q.push_back(it);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upload(input int id, input bit rnd, input bit gaps, input bit mid_start,
                          input int first_val, input bit rf_check, input int abort_at);
        int d0;
        logic [11:0] val;
        d0 = done_cnt;
        up_start  = 1'b1;
        up_tex_id = 5'(id);
        step();
        up_start = 1'b0;
        chk("up_busy after start", 32'({busy1, busy0}), 32'(2'b11));
        chk("up_ready after start", 32'({ready1, ready0}), 32'(2'b11));
        if (rf_check) begin
            rd_valid = 1'b1; rd_tex_id = 5'd1; rd_u = '0; rd_v = '0;
            step();
        end
        for (int i = 0; i < int'(TEXELS); i++) begin
            if (i == abort_at) begin
                up_valid = 1'b0;
                rst = 1'b1;
                #1;
                chk("reset up ctl", 32'({ready0, busy0, done0, err0, ready1, busy1, done1, err1}), 0);
                chk("reset rd_out_valid", 32'({ov1, ov0}), 0);
                chk("reset rd_color", 32'({col1, col0}), 0);
                return;
            end
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    up_valid = 1'b0;
                    step();
                end
            end
            val = rnd ? 12'($urandom) : 12'(i);
            if (i == 0 && first_val >= 0) val = 12'(first_val);
            up_valid = 1'b1;
            up_color = val;
            m_mem[id*TEXELS + i] = val;
            m_wr[id*TEXELS + i]  = 1'b1;
            if (mid_start && i == int'(TEXELS) / 2) begin
                up_start = 1'b1; up_tex_id = 5'd2;
            end
            step();
            up_start = 1'b0;
            if (mid_start && i == int'(TEXELS) / 2)
                chk("up_start in LOAD ignored", 32'({busy1, busy0}), 32'(2'b11));
            if (rf_check && i == 0) begin
                chk("read-first valid", 32'(ov0), 1);
                chk("read-first old data", 32'(col0), 32'(12'hAAA));
                rd_valid = 1'b0;
            end
            if (rf_check && i == 1) chk("read after write new data", 32'(col0), 32'(12'h555));
        end
        up_valid = 1'b0;
        chk("up_done pulse", 32'({done1, done0}), 32'(2'b11));
        chk("up_busy after last", 32'({busy1, busy0}), 0);
        step();
        chk("up_done one cycle", 32'({done1, done0}), 0);
        chk("up_done count", 32'(done_cnt - d0), 1);
    endtask

    task automatic rand_reads(input int n, input bit cont);
        int pick;
        for (int i = 0; i < n; i++) begin
            rd_valid = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
            pick = int'($urandom_range(0, 9));
            case (pick)
                0: rd_tex_id = 5'd3;
                1: rd_tex_id = 5'd7;
                2: rd_tex_id = 5'd1;
                3: rd_tex_id = 5'd0;
                4: rd_tex_id = 5'($urandom_range(16, 31));
                default: rd_tex_id = 5'($urandom_range(0, 15));
            endcase
            rd_u = 8'($urandom);
            rd_v = 8'($urandom);
            step();
        end
        rd_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        tbl[0] = '{3,   5,   2, 12'h085, 12'h085};
        tbl[1] = '{3,  69,   2, 12'h085, 12'h0BF};
        tbl[2] = '{3, 200,   0, 12'h008, 12'h03F};
        tbl[3] = '{3,  63,  63, 12'hFFF, 12'hFFF};
        tbl[4] = '{3,  64,   0, 12'h000, 12'h03F};
        tbl[5] = '{3,   0, 255, 12'hFC0, 12'hFC0};
        tbl[6] = '{16,  5,   2, 12'h000, 12'h000};
        tbl[7] = '{3, 130,  70, 12'h182, 12'hFFF};
        tbl[8] = '{31,  0,   0, 12'h000, 12'h000};

        #2 rst = 1'b1;
        #1;
        chk("reset up ctl", 32'({ready0, busy0, done0, err0, ready1, busy1, done1, err1}), 0);
        chk("reset rd_out_valid", 32'({ov1, ov0}), 0);
        chk("reset rd_color", 32'({col1, col0}), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Invalid upload ids are rejected with a one-cycle error pulse.
        for (int k = 0; k < 2; k++) begin
            up_start  = 1'b1;
            up_tex_id = (k == 0) ? 5'd16 : 5'd31;
            step();
            up_start = 1'b0;
            chk("up_err pulse", 32'({err1, err0}), 32'(2'b11));
            chk("up_busy on bad id", 32'({busy1, busy0}), 0);
            step();
            chk("up_err one cycle", 32'({err1, err0}), 0);
        end

        upload(3, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1);

        for (int i = 0; i < 9; i++) begin
            rd_valid  = 1'b1;
            rd_tex_id = 5'(tbl[i].id);
            rd_u      = 8'(tbl[i].u);
            rd_v      = 8'(tbl[i].v);
            step();
            rd_valid = 1'b0;
            chk($sformatf("tbl[%0d] not yet valid", i), 32'({ov1, ov0}), 0);
            step();
            chk($sformatf("tbl[%0d] valid", i), 32'({ov1, ov0}), 32'(2'b11));
            chk($sformatf("tbl[%0d] wrap color", i), 32'(col0), 32'(tbl[i].e0));
            chk($sformatf("tbl[%0d] clamp color", i), 32'(col1), 32'(tbl[i].e1));
        end

        fork
            upload(7, 1'b1, 1'b1, 1'b1, -1, 1'b0, -1);
            rand_reads(2500, 1'b0);
        join
        rand_reads(500, 1'b1);

        upload(1, 1'b1, 1'b0, 1'b0, 12'hAAA, 1'b0, -1);
        upload(1, 1'b1, 1'b0, 1'b0, 12'h555, 1'b1, 100);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("idle after reset", 32'({busy1, busy0}), 0);
        up_valid = 1'b1;
        up_color = 12'h123;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("up_valid ignored in idle", 32'({ready1, busy1, ready0, busy0}), 0);
        end
        up_valid = 1'b0;

        upload(0, 1'b1, 1'b1, 1'b0, -1, 1'b0, -1);
        rand_reads(800, 1'b0);
        rand_reads(200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
